// File: rtl/toothless_pkg.sv
// Shared definitions for the load/store path.
//   lsu_state_e     : load/store unit FSM states
//   DATA_TYPE_*     : 2-bit access-size codes shared with the decoder
//   lsu_req_legal() : true when a size/offset pair can be issued to memory
package toothless_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] DATA_TYPE_BYTE    = 2'b00;
  localparam logic [1:0] DATA_TYPE_HALF    = 2'b01;
  localparam logic [1:0] DATA_TYPE_WORD    = 2'b10;
  localparam logic [1:0] DATA_TYPE_INVALID = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_WAIT_GNT    = 2'd1,
    LSU_WAIT_RVALID = 2'd2
  } lsu_state_e;

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic lsu_req_legal(input logic [1:0] data_type,
                                         input logic [1:0] byte_off);
    logic legal;
    legal = 1'b0;
    case (data_type)
      DATA_TYPE_BYTE: legal = 1'b1;
      DATA_TYPE_HALF: legal = ~byte_off[0];
      DATA_TYPE_WORD: legal = (byte_off == 2'b00);
      default:        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the load/store unit.
//   Store side: i_st_type/i_st_off/i_st_wdata -> o_be (byte enables) and
//               o_wdata (store data replicated across every lane it may hit).
//   Load side : i_ld_type/i_ld_off/i_ld_sign/i_ld_rdata -> o_ld_data, the
//               addressed byte/half shifted to bit 0 and sign/zero extended.
module lsu_align
  import toothless_pkg::*;
(
  input  logic [1:0]  i_st_type,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_type,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sign,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    case (i_st_type)
      DATA_TYPE_BYTE: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      DATA_TYPE_HALF: begin
        o_be    = 4'b0011 << i_st_off;
        o_wdata = {2{i_st_wdata[15:0]}};
      end
      DATA_TYPE_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_st_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  // Bring the addressed byte to lane 0 before masking/extension.
  assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_shifted;
    case (i_ld_type)
      DATA_TYPE_BYTE: o_ld_data = {{24{i_ld_sign & w_shifted[7]}},  w_shifted[7:0]};
      DATA_TYPE_HALF: o_ld_data = {{16{i_ld_sign & w_shifted[15]}}, w_shifted[15:0]};
      default:        o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one data-memory transfer at a time over a
// req/gnt/rvalid handshake and returns aligned, extended load data.
//   clk, rst (sync, active-high)
//   lsu_req_i/we/type/sign_ext/addr/wdata : request from the decode/ALU stage
//   lsu_rdata_o, lsu_done_o, lsu_err_o, lsu_busy_o : result/status to the core
//   data_* : data-memory bus
//   lsu_state_o : current FSM state, for debug/observation
//
// Handshake: data_req_o is held high, with addr/we/be/wdata stable, from the
// cycle after the request is accepted until the cycle data_gnt_i is seen high;
// the transfer then completes on the first data_rvalid_i, and lsu_done_o
// pulses in the following cycle. gnt/rvalid arriving in any other state are
// ignored.
module load_store_unit
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  output logic                  lsu_busy_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output lsu_state_e            lsu_state_o
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_complete;

  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [1:0]            r_type;
  logic                  r_sign;
  logic [1:0]            r_off;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_done;
  logic                  r_err;

  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;

  // Store lanes come from the live request (captured on accept); the load
  // extract uses the captured size/offset since it runs at response time.
  lsu_align u_align (
    .i_st_type  (lsu_type_i),
    .i_st_off   (lsu_addr_i[1:0]),
    .i_st_wdata (lsu_wdata_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_type  (r_type),
    .i_ld_off   (r_off),
    .i_ld_sign  (r_sign),
    .i_ld_rdata (data_rdata_i),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (lsu_req_legal(lsu_type_i, lsu_addr_i[1:0])) begin
            w_accept    = 1'b1;
            w_state_nxt = LSU_WAIT_GNT;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      LSU_WAIT_GNT: begin
        if (data_gnt_i) begin
          w_state_nxt = LSU_WAIT_RVALID;
        end
      end
      LSU_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          w_complete  = 1'b1;
          w_state_nxt = LSU_IDLE;
        end
      end
      default: begin
        w_state_nxt = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LSU_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_type  <= 2'b00;
      r_sign  <= 1'b0;
      r_off   <= 2'b00;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_complete;
      r_err   <= w_reject;
      if (w_accept) begin
        r_addr  <= {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
        r_we    <= lsu_we_i;
        r_type  <= lsu_type_i;
        r_sign  <= lsu_sign_ext_i;
        r_off   <= lsu_addr_i[1:0];
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      // Stores report zero so the RF never sees stale bus data.
      if (w_complete) begin
        r_rdata <= r_we ? '0 : w_ld_data;
      end
    end
  end

  assign data_req_o   = (r_state == LSU_WAIT_GNT);
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;

  assign lsu_rdata_o  = r_rdata;
  assign lsu_done_o   = r_done;
  assign lsu_err_o    = r_err;
  // The completing transition lands in IDLE, so busy is already low while
  // done/err pulse.
  assign lsu_busy_o   = (r_state != LSU_IDLE);
  assign lsu_state_o  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import toothless_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic        lsu_sign_ext_i = 1'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_done_o;
  logic        lsu_err_o;
  logic        lsu_busy_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = 32'h0;
  lsu_state_e  lsu_state_o;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_type_i     (lsu_type_i),
    .lsu_sign_ext_i (lsu_sign_ext_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_err_o      (lsu_err_o),
    .lsu_busy_o     (lsu_busy_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_wdata_o   (data_wdata_o),
    .data_rdata_i   (data_rdata_i),
    .lsu_state_o    (lsu_state_o)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          gnt_dly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [1:0] typ, input logic sx,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] mem, input int gnt_dly, input logic err,
                               input logic [31:0] e_addr, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.typ = typ; v.sx = sx; v.addr = addr; v.wdata = wdata; v.mem = mem;
    v.gnt_dly = gnt_dly; v.err = err; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Byte-array reference model for random legal transfers.
  function automatic vec_t mk_rand();
    vec_t v;
    int   n;
    int   off;
    logic [7:0] b;
    v.we    = 1'($urandom_range(0, 1));
    v.typ   = 2'($urandom_range(0, 2));
    v.sx    = 1'($urandom_range(0, 1));
    n       = (v.typ == 2'b00) ? 1 : (v.typ == 2'b01) ? 2 : 4;
    off     = (n == 1) ? $urandom_range(0, 3) : (n == 2) ? 2 * $urandom_range(0, 1) : 0;
    v.addr  = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
    v.wdata = $urandom();
    v.mem   = $urandom();
    v.gnt_dly = $urandom_range(0, 3);
    v.err   = 1'b0;
    v.e_addr = v.addr & 32'hFFFF_FFFC;
    v.e_be  = 4'b0000;
    for (int k = 0; k < n; k++) v.e_be[off + k] = 1'b1;
    for (int k = 0; k < 4; k++) v.e_wdata[8*k +: 8] = v.wdata[8*(k % n) +: 8];
    v.e_rdata = 32'h0;
    if (!v.we) begin
      b = 8'h0;
      for (int k = 0; k < n; k++) begin
        b = v.mem[8*(off + k) +: 8];
        v.e_rdata[8*k +: 8] = b;
      end
      for (int k = 8 * n; k < 32; k++) v.e_rdata[k] = v.sx & b[7];
    end
    return v;
  endfunction

  // ---------------- scoreboard: done monitor ----------------
  always @(negedge clk) begin
    if (lsu_done_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        check("done_rdata", lsu_rdata_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    lsu_req_i      = 1'b1;
    lsu_we_i       = v.we;
    lsu_type_i     = v.typ;
    lsu_sign_ext_i = v.sx;
    lsu_addr_i     = v.addr;
    lsu_wdata_i    = v.wdata;
    if (!v.err) exp_q.push_back(v.e_rdata);
    @(negedge clk);
    lsu_req_i   = 1'b0;
    lsu_addr_i  = $urandom();
    lsu_wdata_i = $urandom();
    if (v.err) begin
      check("err_pulse", 32'(lsu_err_o), 32'd1);
      check("err_no_req", 32'(data_req_o), 32'd0);
      check("err_busy", 32'(lsu_busy_o), 32'd0);
      @(negedge clk);
      check("err_clear", 32'(lsu_err_o), 32'd0);
      check("err_no_req2", 32'(data_req_o), 32'd0);
      check("err_busy2", 32'(lsu_busy_o), 32'd0);
    end else begin
      for (int c = 0; c <= v.gnt_dly; c++) begin
        if (c > 0) @(negedge clk);
        check("req_high", 32'(data_req_o), 32'd1);
        check("busy_gnt", 32'(lsu_busy_o), 32'd1);
        check("addr_o", data_addr_o, v.e_addr);
        check("be_o", 32'(data_be_o), 32'(v.e_be));
        check("wdata_o", data_wdata_o, v.e_wdata);
        check("we_o", 32'(data_we_o), 32'(v.we));
        if (c == v.gnt_dly) data_gnt_i = 1'b1;
      end
      @(negedge clk);
      data_gnt_i = 1'b0;
      check("req_dropped", 32'(data_req_o), 32'd0);
      check("busy_rvalid", 32'(lsu_busy_o), 32'd1);
      check("no_early_done", 32'(lsu_done_o), 32'd0);
      data_rvalid_i = 1'b1;
      data_rdata_i  = v.mem;
      @(negedge clk);
      data_rvalid_i = 1'b0;
      data_rdata_i  = $urandom();
      check("done_pulse", 32'(lsu_done_o), 32'd1);
      check("busy_at_done", 32'(lsu_busy_o), 32'd0);
      @(negedge clk);
      check("done_single", 32'(lsu_done_o), 32'd0);
      check("rdata_hold", lsu_rdata_o, v.e_rdata);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //        we    typ    sx    addr          wdata         mem           dly err  e_addr        e_be     e_wdata       e_rdata
    vecs.push_back(mkv(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mkv(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mkv(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080));
    vecs.push_back(mkv(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_BEEF));
    vecs.push_back(mkv(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_1234, 32'h0,       3, 1'b0, 32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0));
    vecs.push_back(mkv(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        32'h1234_8001, 1, 1'b0, 32'h0000_0200, 4'b0011, 32'h0,        32'hFFFF_8001));
    vecs.push_back(mkv(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1'b0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mkv(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h1122_3344, 0, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0033));
    vecs.push_back(mkv(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0,        32'hCAFE_F00D, 2, 1'b0, 32'h0000_0404, 4'b1111, 32'h0,        32'hCAFE_F00D));
    vecs.push_back(mkv(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_5555, 32'h0,       0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mkv(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h7FFF_0000, 0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_7FFF));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdata", lsu_rdata_o, 32'h0);
    check("rst_done", 32'(lsu_done_o), 32'd0);
    check("rst_err", 32'(lsu_err_o), 32'd0);
    check("rst_busy", 32'(lsu_busy_o), 32'd0);
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_addr", data_addr_o, 32'h0);
    check("rst_we", 32'(data_we_o), 32'd0);
    check("rst_be", 32'(data_be_o), 32'd0);
    check("rst_wdata", data_wdata_o, 32'h0);
    check("rst_state", 32'(lsu_state_o), 32'(LSU_IDLE));
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for rvalid, then a late rvalid
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = DATA_TYPE_WORD;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0000_0500;
    @(negedge clk);
    lsu_req_i = 1'b0;
    check("mr_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    check("mr_state", 32'(lsu_state_o), 32'(LSU_WAIT_RVALID));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy", 32'(lsu_busy_o), 32'd0);
    check("mr_req_low", 32'(data_req_o), 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1357_9BDF;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    check("mr_no_done", 32'(lsu_done_o), 32'd0);
    check("mr_idle", 32'(lsu_state_o), 32'(LSU_IDLE));
    repeat (2) @(negedge clk);
    check("mr_no_done2", 32'(lsu_done_o), 32'd0);
    run_vec(mkv(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 32'h2468_ACE0, 0, 1'b0,
                32'h0000_0600, 4'b1111, 32'h0, 32'h2468_ACE0));

    // Random legal traffic against the byte-array model
    for (int i = 0; i < 30; i++) run_vec(mk_rand());

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
